// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and default destinations for the regfile write arbiter
package regfile_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    LO_PEND = 1'b1
  } arb_state_e;

  localparam int DEF_HI_REG = 19;
  localparam int DEF_LO_REG = 20;

  // Request/grant bit positions used by the alu/ld round-robin.
  localparam int RR_ALU = 0;
  localparam int RR_LD  = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, one-hot grant, pointer moves on accept
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr=0 favours req[0]; after a grant the other requester is favoured.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (!ptr) begin
      grant[0] = req[0];
      grant[1] = req[1] & ~req[0];
    end else begin
      grant[1] = req[1];
      grant[0] = req[0] & ~req[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - alu/ld/mul writeback arbiter onto one regfile write port
// REGFILE_ARB_MUL_DUAL_EN: multiply writes HI then LO over two cycles; otherwise LO only.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int HI_REG = DEF_HI_REG,
  parameter int LO_REG = DEF_LO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_REG);
  localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(LO_REG);

  logic              can_grant;
  logic              mul_last;
  logic              mul_first;
  logic [1:0]        rr_req;
  logic [1:0]        rr_grant;
  logic              rr_accept;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

`ifdef REGFILE_ARB_MUL_DUAL_EN
  arb_state_e        state;
  arb_state_e        state_next;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_ready) state_next = LO_PEND;
      LO_PEND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    can_grant = !rst && (state == IDLE);
    busy      = (state == LO_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
    end else if (mul_ready) begin
      lo_q <= mul_lo;
    end
  end
`else
  logic unused_mul_hi;

  assign can_grant     = !rst;
  assign busy          = 1'b0;
  assign unused_mul_hi = ^{mul_hi, HI_ADDR};
`endif

  // mul normally wins, but yields to alu/ld right after its own grant so it cannot starve them.
  assign mul_first = mul_valid && !(mul_last && (alu_valid || ld_valid));

  assign rr_req[RR_ALU] = alu_valid;
  assign rr_req[RR_LD]  = ld_valid;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (rr_req),
    .accept (rr_accept),
    .grant  (rr_grant)
  );

  always_comb begin
    mul_ready = can_grant && mul_first;
    alu_ready = can_grant && !mul_first && rr_grant[RR_ALU];
    ld_ready  = can_grant && !mul_first && rr_grant[RR_LD];
    rr_accept = alu_ready || ld_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_last <= 1'b0;
    end else if (mul_ready) begin
      mul_last <= 1'b1;
    end else if (rr_accept) begin
      mul_last <= 1'b0;
    end
  end

  // Writes to address 0 still handshake but never assert the write enable.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = rf_waddr;
    wr_data_d = rf_wdata;
    if (alu_ready) begin
      wr_en_d   = (alu_addr != '0);
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (ld_ready) begin
      wr_en_d   = (ld_addr != '0);
      wr_addr_d = ld_addr;
      wr_data_d = ld_data;
    end else if (mul_ready) begin
`ifdef REGFILE_ARB_MUL_DUAL_EN
      wr_en_d   = (HI_ADDR != '0);
      wr_addr_d = HI_ADDR;
      wr_data_d = mul_hi;
`else
      wr_en_d   = (LO_ADDR != '0);
      wr_addr_d = LO_ADDR;
      wr_data_d = mul_lo;
`endif
    end
`ifdef REGFILE_ARB_MUL_DUAL_EN
    else if (state == LO_PEND) begin
      wr_en_d   = (LO_ADDR != '0);
      wr_addr_d = LO_ADDR;
      wr_data_d = lo_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= wr_en_d;
      rf_waddr <= wr_addr_d;
      rf_wdata <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
// Follows REGFILE_ARB_MUL_DUAL_EN to pick the one- or two-beat multiply expectation.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HI = 19;
  localparam int LO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, ld_valid, ld_ready, mul_valid, mul_ready;
  logic [AW-1:0] alu_addr, ld_addr;
  logic [DW-1:0] alu_data, ld_data, mul_hi, mul_lo;
  logic          rf_we, busy;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HI_REG(HI), .LO_REG(LO)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model: who is favoured next, whether mul just won, whether a LO beat is owed.
  bit  prefer_ld = 0;
  bit  mul_won_last = 0;
  bit  lo_owed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write and its cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          mon_e = exp_q.pop_front();
          chk("missing_write", 64'(mon_e.addr), 64'hFFFF);
        end
        if (rf_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(rf_waddr), 64'hFFFF);
          end else begin
            mon_e = exp_q.pop_front();
            chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("write_addr", 64'(rf_waddr), 64'(mon_e.addr));
            chk("write_data", 64'(rf_wdata), 64'(mon_e.data));
          end
        end
      end
    end
  end

  // One cycle of stimulus; g returns the model's grant (0 none, 1 alu, 2 ld, 3 mul).
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                      input bit mv, input logic [DW-1:0] mh, input logic [DW-1:0] ml,
                      output int g);
    bit mul_wins;
    @(negedge clk);
    #1;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
    mul_valid = mv; mul_hi   = mh; mul_lo   = ml;
    #1;
    g = 0;
    mul_wins = mv && !(mul_won_last && (av || lv));
    if (!lo_owed) begin
      if (mul_wins)     g = 3;
      else if (av && lv) g = prefer_ld ? 2 : 1;
      else if (av)      g = 1;
      else if (lv)      g = 2;
    end
    chk("alu_ready", 64'(alu_ready), 64'(g == 1));
    chk("ld_ready",  64'(ld_ready),  64'(g == 2));
    chk("mul_ready", 64'(mul_ready), 64'(g == 3));
    chk("busy",      64'(busy),      64'(lo_owed));
    lo_owed = 0;
    case (g)
      1: begin
        prefer_ld = 1; mul_won_last = 0;
        if (aa != 0) exp_q.push_back('{cyc + 1, aa, ad});
      end
      2: begin
        prefer_ld = 0; mul_won_last = 0;
        if (la != 0) exp_q.push_back('{cyc + 1, la, ldd});
      end
      3: begin
        mul_won_last = 1;
`ifdef REGFILE_ARB_MUL_DUAL_EN
        exp_q.push_back('{cyc + 1, AW'(HI), mh});
        exp_q.push_back('{cyc + 2, AW'(LO), ml});
        lo_owed = 1;
`else
        exp_q.push_back('{cyc + 1, AW'(LO), ml});
`endif
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, '0, '0, g);
  endtask

  // Reset with every requester asserting: nothing may leak out while rst is high.
  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1;
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'h11;
    ld_valid  = 1; ld_addr  = 5'd6; ld_data  = 32'h22;
    mul_valid = 1; mul_hi   = 32'h33; mul_lo = 32'h44;
    exp_q.delete();
    prefer_ld = 0; mul_won_last = 0; lo_owed = 0;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_ld_ready",  64'(ld_ready),  64'd0);
    chk("rst_mul_ready", 64'(mul_ready), 64'd0);
    chk("rst_rf_we",     64'(rf_we),     64'd0);
    chk("rst_rf_waddr",  64'(rf_waddr),  64'd0);
    chk("rst_rf_wdata",  64'(rf_wdata),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    repeat (n) @(negedge clk);
    #1;
    rst = 0;
    alu_valid = 0; ld_valid = 0; mul_valid = 0;
  endtask

  bit            rav = 0, rlv = 0, rmv = 0;
  logic [AW-1:0] raa, rla;
  logic [DW-1:0] rad, rld, rmh, rml;
  int            g;
  int            order[$];

  initial begin
    rst = 1;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    ld_valid  = 0; ld_addr  = '0; ld_data  = '0;
    mul_valid = 0; mul_hi   = '0; mul_lo   = '0;
    do_reset(2);

    // Single alu write.
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, '0, g);
    chk("alu_single_grant", 64'(g), 64'd1);
    idle(2);

    // alu and ld contend: alternate starting with alu.
    do_reset(1);
    order.delete();
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'hA000 + i, 1, 5'd4, 32'hB000 + i, 0, '0, '0, g);
      order.push_back(g);
    end
    for (int i = 0; i < 4; i++) chk("rr_order", 64'(order[i]), 64'((i % 2) + 1));
    idle(2);

    // Multiply; the following cycle all requesters are refused under the two-beat build.
    step(0, '0, '0, 0, '0, '0, 1, 32'h1, 32'h2, g);
    step(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 1, 32'h5, 32'h6, g);
    idle(3);

    // mul and alu held: neither starves.
    do_reset(1);
    order.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 5'd7, 32'hC0DE0000 + i, 0, '0, '0, 1, 32'h100 + i, 32'h200 + i, g);
      if (g != 0) order.push_back(g);
    end
    for (int i = 0; i < 4; i++) chk("mul_alu_order", 64'(order[i]), 64'((i % 2 == 0) ? 3 : 1));
    idle(3);

    // ld to address 0 handshakes without a write.
    step(0, '0, '0, 1, 5'd0, 32'hFFFF, 0, '0, '0, g);
    chk("ld_zero_grant", 64'(g), 64'd2);
    idle(2);

    // Reset lands in the cycle after a mul grant: no LO write afterwards.
    step(0, '0, '0, 0, '0, '0, 1, 32'hAB, 32'hCD, g);
    do_reset(2);
    idle(4);

    // Randomized traffic with requesters holding their payload until accepted.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(2);
      if (!rav) begin rav = ($urandom_range(0, 99) < 55); raa = AW'($urandom_range(0, 31)); rad = $urandom; end
      if (!rlv) begin rlv = ($urandom_range(0, 99) < 55); rla = AW'($urandom_range(0, 31)); rld = $urandom; end
      if (!rmv) begin rmv = ($urandom_range(0, 99) < 30); rmh = $urandom; rml = $urandom; end
      step(rav, raa, rad, rlv, rla, rld, rmv, rmh, rml, g);
      if (g == 1) rav = 0;
      if (g == 2) rlv = 0;
      if (g == 3) rmv = 0;
    end
    idle(4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter HI_REG, default 19, destination of multiply high word.
REQ-004 SHALL have parameter LO_REG, default 20, destination of multiply low word.
REQ-005 SHALL have port clk, in, 1, clock; rst, in, 1, reset (asynchronous, active-high).
REQ-006 SHALL have ports alu_valid in 1, alu_ready out 1, alu_addr in ADDR_W, alu_data in DATA_W; ALU writeback request.
REQ-007 SHALL have ports ld_valid in 1, ld_ready out 1, ld_addr in ADDR_W, ld_data in DATA_W; load writeback request.
REQ-008 SHALL have ports mul_valid in 1, mul_ready out 1, mul_hi in DATA_W, mul_lo in DATA_W; multiply result request.
REQ-009 SHALL have ports rf_we out 1, rf_waddr out ADDR_W, rf_wdata out DATA_W; single register-bank write port.
REQ-010 SHALL have port busy, out, 1, high while a multiply low-word write is pending.

Function
REQ-011 A request SHALL transfer in the cycle where valid and ready are both high; requesters SHALL hold addr/data stable while valid and not ready.
REQ-012 The FSM SHALL have states IDLE and LO_PEND; in LO_PEND all ready outputs SHALL be 0.
REQ-013 In IDLE at most one ready SHALL be high per cycle; the ready SHALL go to the granted valid requester, combinationally from the valids and the arbiter state.
REQ-014 Priority in IDLE SHALL be mul first, then round-robin between alu and ld, unless mul_last=1 and alu or ld is valid, in which case mul ranks last.
REQ-015 The round-robin pointer SHALL toggle to the other requester only on an alu or ld grant. mul_last SHALL set on a mul grant and clear on an alu or ld grant.
REQ-016 The write port SHALL be registered with one-cycle latency: a grant in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1.
REQ-017 An alu or ld grant SHALL drive rf_waddr/rf_wdata from that requester in N+1.
REQ-018 With the feature macro defined, a mul grant in N SHALL drive (HI_REG, mul_hi) in N+1 and enter LO_PEND. It SHALL drive (LO_REG, captured mul_lo) in N+2 and return to IDLE.
REQ-019 A granted write to address 0 SHALL complete the handshake but drive rf_we=0 in N+1.
REQ-020 rf_we SHALL be 0 in any cycle that has no write scheduled from the previous cycle.
REQ-021 busy SHALL equal (state==LO_PEND).

Reset
REQ-022 While rst is high, rf_we, rf_waddr, rf_wdata, busy and all ready outputs SHALL be 0. State SHALL be IDLE, the round-robin pointer SHALL select alu, and mul_last SHALL be 0.
REQ-023 Assertion of rst in LO_PEND SHALL discard the pending low word; no write to LO_REG SHALL occur after release.

Configuration
REQ-024 Macro REGFILE_ARB_MUL_DUAL_EN SHALL select multiply handling.
REQ-025 Defined: two-beat HI/LO sequence per REQ-018.
REQ-026 Undefined: a mul grant SHALL drive (LO_REG, mul_lo) in N+1 only. mul_hi SHALL be ignored, LO_PEND SHALL not exist, and busy SHALL be tied 0.

Structure
REQ-027 Package regfile_arb_pkg SHALL hold the state enum (IDLE, LO_PEND) and default HI_REG/LO_REG constants.
REQ-028 The alu/ld round-robin SHALL be a sub-module rr_arb2 (2 requests, grant one-hot, pointer update on accept).

Verification
REQ-029 alu_valid=1 with addr 5 and data 0xDEADBEEF, others idle -> alu_ready=1 in cycle N, and rf_we=1, waddr=5, wdata=0xDEADBEEF in N+1.
REQ-030 alu and ld both valid for 4 cycles (addrs 3, 4) -> grants alternate alu, ld, alu, ld, and rf_waddr sequence is 3, 4, 3, 4.
REQ-031 (macro defined) mul_valid with hi=0x1, lo=0x2 -> waddr 19/data 0x1 in N+1, waddr 20/data 0x2 in N+2, busy=1 in N+1, all ready=0 in N+1.
REQ-032 mul_valid and alu_valid held high -> grant order mul, alu, mul, alu (no starvation); under macro defined, each mul grant is followed by a LO_PEND cycle.
REQ-033 ld write to addr 0 -> ld_ready=1 and rf_we=0 in next cycle. rst pulsed during LO_PEND -> no write to 20 after release, and all outputs are 0 during rst.
